adder_cla_24bit: RTL and testbench



---
 rtl/adder_cla_24bit_pkg.sv | 41 ++++
 rtl/adder_cla_4bit.sv | 35 +++
 rtl/adder_cla_24bit.sv | 81 ++++++++
 tb/tb_adder_cla_24bit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_cla_24bit_pkg.sv
// Shared CPU24 word and carry-lookahead definitions used by the 24-bit adder.
// Bit numbering is big-endian throughout: index 0 is the MSB.
package adder_cla_24bit_pkg;

    localparam int WORD_LENGTH     = 24;
    localparam int CLA_GROUP_WIDTH = 4;
    localparam int CLA_GROUPS      = WORD_LENGTH / CLA_GROUP_WIDTH;

    typedef logic [0:WORD_LENGTH-1]     word_t;
    typedef logic [0:CLA_GROUP_WIDTH-1] nibble_t;
    typedef logic [0:CLA_GROUPS-1]      group_vec_t;

    // Carry into group j, written as a flat sum of products of the group
    // generate/propagate terms and the word carry-in. j = -1 yields the
    // carry out of the MSB group. With a constant j this elaborates to a
    // single two-level term, so no carry ripples from group to group.
    function automatic logic lookahead_carry(
        input group_vec_t g,
        input group_vec_t p,
        input logic       cin,
        input int         j
    );
        logic carry;
        logic run_p;
        carry = 1'b0;
        for (int k = j + 1; k < CLA_GROUPS; k++) begin
            run_p = 1'b1;
            for (int m = j + 1; m < k; m++) begin
                run_p = run_p & p[m];
            end
            carry = carry | (g[k] & run_p);
        end
        run_p = 1'b1;
        for (int m = j + 1; m < CLA_GROUPS; m++) begin
            run_p = run_p & p[m];
        end
        carry = carry | (run_p & cin);
        return carry;
    endfunction

endpackage

// File: rtl/adder_cla_4bit.sv
// 4-bit carry-lookahead group. Bit 0 is the MSB; cin enters at bit 3.
// Produces the group sum plus group generate G and propagate P for the
// second-level lookahead unit.
module adder_cla_4bit
    import adder_cla_24bit_pkg::*;
(
    input  nibble_t a,
    input  nibble_t b,
    input  logic    cin,
    output nibble_t s,
    output logic    G,
    output logic    P
);

    nibble_t w_g;
    nibble_t w_p;
    nibble_t w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Internal lookahead carries, each computed directly from cin.
    assign w_c[3] = cin;
    assign w_c[2] = w_g[3] | (w_p[3] & cin);
    assign w_c[1] = w_g[2] | (w_p[2] & w_g[3]) | (w_p[2] & w_p[3] & cin);
    assign w_c[0] = w_g[1] | (w_p[1] & w_g[2]) | (w_p[1] & w_p[2] & w_g[3])
                  | (w_p[1] & w_p[2] & w_p[3] & cin);

    assign s = w_p ^ w_c;

    assign G = w_g[0] | (w_p[0] & w_g[1]) | (w_p[0] & w_p[1] & w_g[2])
             | (w_p[0] & w_p[1] & w_p[2] & w_g[3]);
    assign P = &w_p;

endmodule

// File: rtl/adder_cla_24bit.sv
// 24-bit two-level carry-lookahead adder with registered sum and carry-out.
// Six adder_cla_4bit groups feed a flat second-level lookahead unit.
// Optional: define ADDER_CLA_OVF_EN to add the registered signed-overflow
// output ovf.
module adder_cla_24bit
    import adder_cla_24bit_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  word_t a,
    input  word_t b,
    input  logic  inC,
    output word_t s,
    output logic  outC
`ifdef ADDER_CLA_OVF_EN
    ,
    output logic  ovf
`endif
);

    group_vec_t w_grp_g;
    group_vec_t w_grp_p;
    group_vec_t w_grp_cin;
    word_t      w_sum;
    logic       w_cout;

    word_t      r_s;
    logic       r_outC;

    // Group 0 holds bits 0..3 (MSB); group 5 holds bits 20..23 and takes inC.
    for (genvar j = 0; j < CLA_GROUPS; j++) begin : g_grp
        assign w_grp_cin[j] = lookahead_carry(w_grp_g, w_grp_p, inC, j);

        adder_cla_4bit u_grp (
            .a   (a[j*CLA_GROUP_WIDTH +: CLA_GROUP_WIDTH]),
            .b   (b[j*CLA_GROUP_WIDTH +: CLA_GROUP_WIDTH]),
            .cin (w_grp_cin[j]),
            .s   (w_sum[j*CLA_GROUP_WIDTH +: CLA_GROUP_WIDTH]),
            .G   (w_grp_g[j]),
            .P   (w_grp_p[j])
        );
    end

    assign w_cout = lookahead_carry(w_grp_g, w_grp_p, inC, -1);

    // Capture the sum and carry-out one cycle after the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_outC <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            r_s    <= w_sum;
            r_outC <= w_cout;
        end
    end

    assign s    = r_s;
    assign outC = r_outC;

`ifdef ADDER_CLA_OVF_EN
    logic w_c0;
    logic r_ovf;

    // Carry into bit 0 recovered from its sum bit: s0 = a0 ^ b0 ^ c0.
    assign w_c0 = w_sum[0] ^ a[0] ^ b[0];

    // Register signed overflow alongside the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_c0 ^ w_cout;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_adder_cla_24bit.sv
// Self-checking bench for adder_cla_24bit. Expected results are computed from
// a plain integer model and queued when operands are driven, then popped and
// compared one clock later.
module tb_adder_cla_24bit;

    typedef struct packed {
        logic [23:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [0:23] a;
    logic [0:23] b;
    logic        inC;
    logic [0:23] s;
    logic        outC;
    logic        ovf;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_pass;
    int   n_total;

    adder_cla_24bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .inC   (inC),
        .s     (s),
        .outC  (outC)
`ifdef ADDER_CLA_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef ADDER_CLA_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands at the falling edge and queue the model result.
    task automatic apply(input logic [23:0] ta, input logic [23:0] tb, input logic tc);
        logic [24:0] full;
        exp_t        e;
        @(negedge clk);
        a   = ta;
        b   = tb;
        inC = tc;
        full = {1'b0, ta} + {1'b0, tb} + {24'd0, tc};
        e.s = full[23:0];
        e.c = full[24];
        e.v = (ta[23] == tb[23]) && (full[23] != ta[23]);
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = '0; b = '0; inC = 1'b0;
        #1;
        n_total++;
        if (s !== 24'h0 || outC !== 1'b0 || ovf !== 1'b0)
            $display("FAIL reset_initial: s=%h outC=%b ovf=%b want s=000000 outC=0 ovf=0", s, outC, ovf);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        apply(24'hFFFFFF, 24'h000001, 1'b0);
        @(posedge clk); #1;
        last_exp = sb_q.pop_front();
        n_total++;
        if (s !== last_exp.s || outC !== last_exp.c)
            $display("FAIL reset_preload: s=%h outC=%b want s=%h outC=%b", s, outC, last_exp.s, last_exp.c);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        n_total++;
        if (s !== 24'h0 || outC !== 1'b0 || ovf !== 1'b0)
            $display("FAIL reset_async: s=%h outC=%b ovf=%b want s=000000 outC=0 ovf=0", s, outC, ovf);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (s !== 24'h0 || outC !== 1'b0)
            $display("FAIL reset_hold: s=%h outC=%b want s=000000 outC=0", s, outC);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        apply(24'hFFFFFF, 24'h000001, 1'b0);
        @(posedge clk); #1;
        last_exp = sb_q.pop_front();
        n_total++;
        if (s !== 24'h000000 || outC !== 1'b1)
            $display("FAIL reset_release: s=%h outC=%b want s=000000 outC=1", s, outC);
        else n_pass++;
    endtask

    task automatic test_vectors(input string name, input logic [23:0] va[], input logic [23:0] vb[], input logic vc[]);
        exp_t e;
        for (int i = 0; i < va.size(); i++) begin
            apply(va[i], vb[i], vc[i]);
            @(posedge clk); #1;
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL %s[%0d]: scoreboard empty", name, i);
                continue;
            end
            e = sb_q.pop_front();
            if (s !== e.s || outC !== e.c || (`ifdef ADDER_CLA_OVF_EN ovf !== e.v `else 1'b0 `endif))
                $display("FAIL %s[%0d]: s=%h outC=%b ovf=%b want s=%h outC=%b ovf=%b",
                         name, i, s, outC, ovf, e.s, e.c, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        test_vectors("basic", '{24'd0, 24'd10}, '{24'd0, 24'd5}, '{1'b0, 1'b0});
        n_total++;
        if (s !== 24'h00000F || outC !== 1'b0)
            $display("FAIL basic_const: s=%h outC=%b want s=00000F outC=0", s, outC);
        else n_pass++;
    endtask

    task automatic test_group_carry();
        test_vectors("group_carry", '{24'd1, 24'h000FFF, 24'h0FFFFF},
                     '{24'd15, 24'h000001, 24'h000001}, '{1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_wrap();
        test_vectors("wrap", '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF},
                     '{24'h000001, 24'h000000, 24'hFFFFFF}, '{1'b0, 1'b1, 1'b1});
        n_total++;
        if (s !== 24'hFFFFFF || outC !== 1'b1)
            $display("FAIL wrap_const: s=%h outC=%b want s=FFFFFF outC=1", s, outC);
        else n_pass++;
    endtask

    // One operation per cycle; also checks outputs hold between edges.
    task automatic test_back_to_back();
        logic [23:0] ra;
        logic [23:0] rb;
        logic        rc;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                ra = 24'h123456; rb = 24'h654321; rc = 1'b0;
            end else if (i == 1) begin
                ra = 24'h800000; rb = 24'h800000; rc = 1'b0;
            end else begin
                ra = 24'($urandom); rb = 24'($urandom); rc = 1'($urandom);
            end
            apply(ra, rb, rc);
            #1;
            if (i > 0) begin
                n_total++;
                if (s !== last_exp.s || outC !== last_exp.c)
                    $display("FAIL b2b_hold[%0d]: s=%h outC=%b want s=%h outC=%b",
                             i, s, outC, last_exp.s, last_exp.c);
                else n_pass++;
            end
            @(posedge clk); #1;
            last_exp = sb_q.pop_front();
            n_total++;
            if (s !== last_exp.s || outC !== last_exp.c
                || (`ifdef ADDER_CLA_OVF_EN ovf !== last_exp.v `else 1'b0 `endif))
                $display("FAIL b2b[%0d]: s=%h outC=%b ovf=%b want s=%h outC=%b ovf=%b",
                         i, s, outC, ovf, last_exp.s, last_exp.c, last_exp.v);
            else n_pass++;
            if (i == 0) begin
                n_total++;
                if (s !== 24'h777777 || outC !== 1'b0)
                    $display("FAIL b2b_const0: s=%h outC=%b want s=777777 outC=0", s, outC);
                else n_pass++;
            end else if (i == 1) begin
                n_total++;
                if (s !== 24'h000000 || outC !== 1'b1)
                    $display("FAIL b2b_const1: s=%h outC=%b want s=000000 outC=1", s, outC);
                else n_pass++;
            end
        end
    endtask

`ifdef ADDER_CLA_OVF_EN
    task automatic test_ovf();
        test_vectors("ovf", '{24'h7FFFFF, 24'h800000, 24'd5, 24'hFFFFFF},
                     '{24'h000001, 24'hFFFFFF, 24'd3, 24'h000001}, '{1'b0, 1'b0, 1'b0, 1'b0});
        n_total++;
        if (ovf !== 1'b0)
            $display("FAIL ovf_neg_plus_pos: ovf=%b want 0", ovf);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_group_carry();
        test_wrap();
        test_back_to_back();
`ifdef ADDER_CLA_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
